// File: rtl/rv32i_decode_stage_if.sv
// Fetch-to-decode-to-execute handshake and the decoded bundle.
// The decode stage uses the master view; fetch/execute (or a bench) uses the slave view.
interface rv32i_decode_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [4:0]  out_rd;
    logic [31:0] out_imm;
    logic        out_func_sel;
    logic [2:0]  out_alu_func;
    logic        out_alu_bit;
    logic [2:0]  out_br_func;
    logic        out_src_a_pc;
    logic        out_src_a_zero;
    logic        out_src_b_imm;
    logic        out_reg_write;
    logic        out_mem_read;
    logic        out_mem_write;
    logic [2:0]  out_mem_size;
    logic        out_jump;
    logic        out_jalr;
    logic        out_illegal;

    modport master (
        input  in_valid, in_instr, in_pc, flush, out_ready,
        output in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_imm,
               out_func_sel, out_alu_func, out_alu_bit, out_br_func,
               out_src_a_pc, out_src_a_zero, out_src_b_imm, out_reg_write,
               out_mem_read, out_mem_write, out_mem_size, out_jump, out_jalr,
               out_illegal
    );

    modport slave (
        output in_valid, in_instr, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_imm,
               out_func_sel, out_alu_func, out_alu_bit, out_br_func,
               out_src_a_pc, out_src_a_zero, out_src_b_imm, out_reg_write,
               out_mem_read, out_mem_write, out_mem_size, out_jump, out_jalr,
               out_illegal
    );
endinterface

// File: rtl/rv32i_decode_stage.sv
// Registered RV32I decode stage: combinational decode of the fetched word into
// ALU/branch/memory controls, captured in one valid/ready output register.
module rv32i_decode_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    rv32i_decode_stage_if.master        bus
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        func_sel;
        logic [2:0]  alu_func;
        logic        alu_bit;
        logic [2:0]  br_func;
        logic        src_a_pc;
        logic        src_a_zero;
        logic        src_b_imm;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic [2:0]  mem_size;
        logic        jump;
        logic        jalr;
        logic        illegal;
    } dec_t;

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    dec_t        dec_d, dec_q;
    logic [31:0] pc_q;
    logic        valid_d, valid_q;
    logic        load;

    assign instr  = bus.in_instr;
    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        dec_d     = '0;
        dec_d.rs1 = instr[19:15];
        dec_d.rs2 = instr[24:20];
        dec_d.rd  = instr[11:7];
        unique case (opcode)
            OPC_LUI: begin
                dec_d.imm        = imm_u;
                dec_d.src_a_zero = 1'b1;
                dec_d.src_b_imm  = 1'b1;
                dec_d.reg_write  = 1'b1;
            end
            OPC_AUIPC: begin
                dec_d.imm       = imm_u;
                dec_d.src_a_pc  = 1'b1;
                dec_d.src_b_imm = 1'b1;
                dec_d.reg_write = 1'b1;
            end
            OPC_JAL: begin
                // ALU forms the jump target as PC + J-immediate
                dec_d.imm       = imm_j;
                dec_d.src_a_pc  = 1'b1;
                dec_d.src_b_imm = 1'b1;
                dec_d.reg_write = 1'b1;
                dec_d.jump      = 1'b1;
            end
            OPC_JALR: begin
                dec_d.imm       = imm_i;
                dec_d.src_b_imm = 1'b1;
                dec_d.reg_write = 1'b1;
                dec_d.jalr      = 1'b1;
                dec_d.illegal   = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                dec_d.imm      = imm_b;
                dec_d.func_sel = 1'b1;
                dec_d.br_func  = funct3;
                dec_d.illegal  = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OPC_LOAD: begin
                dec_d.imm       = imm_i;
                dec_d.src_b_imm = 1'b1;
                dec_d.reg_write = 1'b1;
                dec_d.mem_read  = 1'b1;
                dec_d.mem_size  = funct3;
                dec_d.illegal   = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            OPC_STORE: begin
                dec_d.imm       = imm_s;
                dec_d.src_b_imm = 1'b1;
                dec_d.mem_write = 1'b1;
                dec_d.mem_size  = funct3;
                dec_d.illegal   = (funct3 > 3'b010);
            end
            OPC_OPIMM: begin
                dec_d.imm       = imm_i;
                dec_d.alu_func  = funct3;
                dec_d.alu_bit   = (funct3 == 3'b101) & instr[30];
                dec_d.src_b_imm = 1'b1;
                dec_d.reg_write = 1'b1;
                if (funct3 == 3'b001)
                    dec_d.illegal = (funct7 != 7'b0000000);
                else if (funct3 == 3'b101)
                    dec_d.illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
            end
            OPC_OP: begin
                dec_d.alu_func  = funct3;
                dec_d.alu_bit   = instr[30];
                dec_d.reg_write = 1'b1;
                if (funct7 == 7'b0100000)
                    dec_d.illegal = (funct3 != 3'b000) && (funct3 != 3'b101);
                else
                    dec_d.illegal = (funct7 != 7'b0000000);
            end
            default: dec_d.illegal = 1'b1;
        endcase

        // An illegal word keeps only its register fields so nothing downstream acts on it
        if (dec_d.illegal) begin
            dec_d         = '0;
            dec_d.rs1     = instr[19:15];
            dec_d.rs2     = instr[24:20];
            dec_d.rd      = instr[11:7];
            dec_d.illegal = 1'b1;
        end
        if (dec_d.rd == 5'd0)
            dec_d.reg_write = 1'b0;
    end

    assign bus.in_ready = !valid_q || bus.out_ready;
    assign load         = bus.in_valid && bus.in_ready;

    always_comb begin
        valid_d = valid_q;
        if (bus.flush)
            valid_d = 1'b0;
        else if (load)
            valid_d = 1'b1;
        else if (bus.out_ready)
            valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pc_q    <= RESET_PC;
            dec_q   <= '0;
        end else begin
            valid_q <= valid_d;
            if (load) begin
                pc_q  <= bus.in_pc;
                dec_q <= dec_d;
            end
        end
    end

    assign bus.out_valid      = valid_q;
    assign bus.out_pc         = pc_q;
    assign bus.out_rs1        = dec_q.rs1;
    assign bus.out_rs2        = dec_q.rs2;
    assign bus.out_rd         = dec_q.rd;
    assign bus.out_imm        = dec_q.imm;
    assign bus.out_func_sel   = dec_q.func_sel;
    assign bus.out_alu_func   = dec_q.alu_func;
    assign bus.out_alu_bit    = dec_q.alu_bit;
    assign bus.out_br_func    = dec_q.br_func;
    assign bus.out_src_a_pc   = dec_q.src_a_pc;
    assign bus.out_src_a_zero = dec_q.src_a_zero;
    assign bus.out_src_b_imm  = dec_q.src_b_imm;
    assign bus.out_reg_write  = dec_q.reg_write;
    assign bus.out_mem_read   = dec_q.mem_read;
    assign bus.out_mem_write  = dec_q.mem_write;
    assign bus.out_mem_size   = dec_q.mem_size;
    assign bus.out_jump       = dec_q.jump;
    assign bus.out_jalr       = dec_q.jalr;
    assign bus.out_illegal    = dec_q.illegal;

endmodule

// File: tb/tb_rv32i_decode_stage.sv
// Table of hand-decoded RV32I words streamed through the stage with a
// scoreboard queue, plus directed backpressure, flush and async-reset sequences.
module tb_rv32i_decode_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] imm;
        logic        illegal, func_sel;
        logic [2:0]  alu_func;
        logic        alu_bit;
        logic [2:0]  br_func;
        logic        src_a_pc, src_a_zero, src_b_imm;
        logic        reg_write, mem_read, mem_write;
        logic [2:0]  mem_size;
        logic        jump, jalr;
    } vec_t;

    localparam int NV = 16;
    localparam int I_ADDI = 0, I_SUB = 1, I_ILL0 = 10;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   pc_ctr = 0;
    vec_t vec [NV];
    vec_t cur_exp;
    vec_t sb_q [$];

    rv32i_decode_stage_if bus ();

    rv32i_decode_stage #(.RESET_PC(RST_PC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic [31:0] instr, logic [4:0] rs1, logic [4:0] rs2,
                                logic [4:0] rd, logic [31:0] imm, logic ill, logic fs,
                                logic [2:0] af, logic ab, logic [2:0] bf, logic apc,
                                logic azero, logic bimm, logic rw, logic mr, logic mw,
                                logic [2:0] ms, logic j, logic jr);
        vec_t v;
        v.instr = instr; v.pc = '0; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.imm = imm;
        v.illegal = ill; v.func_sel = fs; v.alu_func = af; v.alu_bit = ab; v.br_func = bf;
        v.src_a_pc = apc; v.src_a_zero = azero; v.src_b_imm = bimm; v.reg_write = rw;
        v.mem_read = mr; v.mem_write = mw; v.mem_size = ms; v.jump = j; v.jalr = jr;
        return v;
    endfunction

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    task automatic cmp_bundle(vec_t e);
        string t;
        t = $sformatf("%h", e.instr);
        chk({"pc ", t}, bus.out_pc, e.pc);
        chk({"rs1 ", t}, 32'(bus.out_rs1), 32'(e.rs1));
        chk({"rs2 ", t}, 32'(bus.out_rs2), 32'(e.rs2));
        chk({"rd ", t}, 32'(bus.out_rd), 32'(e.rd));
        chk({"imm ", t}, bus.out_imm, e.imm);
        chk({"illegal ", t}, 32'(bus.out_illegal), 32'(e.illegal));
        chk({"func_sel ", t}, 32'(bus.out_func_sel), 32'(e.func_sel));
        chk({"alu_func ", t}, 32'(bus.out_alu_func), 32'(e.alu_func));
        chk({"alu_bit ", t}, 32'(bus.out_alu_bit), 32'(e.alu_bit));
        chk({"br_func ", t}, 32'(bus.out_br_func), 32'(e.br_func));
        chk({"src_a_pc ", t}, 32'(bus.out_src_a_pc), 32'(e.src_a_pc));
        chk({"src_a_zero ", t}, 32'(bus.out_src_a_zero), 32'(e.src_a_zero));
        chk({"src_b_imm ", t}, 32'(bus.out_src_b_imm), 32'(e.src_b_imm));
        chk({"reg_write ", t}, 32'(bus.out_reg_write), 32'(e.reg_write));
        chk({"mem_read ", t}, 32'(bus.out_mem_read), 32'(e.mem_read));
        chk({"mem_write ", t}, 32'(bus.out_mem_write), 32'(e.mem_write));
        chk({"mem_size ", t}, 32'(bus.out_mem_size), 32'(e.mem_size));
        chk({"jump ", t}, 32'(bus.out_jump), 32'(e.jump));
        chk({"jalr ", t}, 32'(bus.out_jalr), 32'(e.jalr));
        $display("txn instr=%h pc=%h rd=%0d imm=%h illegal=%0d", e.instr, bus.out_pc,
                 bus.out_rd, bus.out_imm, bus.out_illegal);
    endtask

    // Scoreboard: pop on consumption, drop on flush of a held bundle, push on acceptance
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid && bus.out_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got instr bundle rd=%0d expected none",
                             bus.out_rd);
                end else begin
                    cmp_bundle(sb_q.pop_front());
                end
            end else if (bus.out_valid && bus.flush && sb_q.size() > 0) begin
                void'(sb_q.pop_front());
            end
            if (bus.in_valid && bus.in_ready && !bus.flush)
                sb_q.push_back(cur_exp);
        end
    end

    task automatic drive(int idx, logic valid);
        cur_exp       = vec[idx];
        cur_exp.pc    = 32'h0000_1000 + 32'(pc_ctr * 4);
        pc_ctr++;
        bus.in_instr  = cur_exp.instr;
        bus.in_pc     = cur_exp.pc;
        bus.in_valid  = valid;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic run_table(bit rnd);
        int i = 0;
        int guard = 0;
        while (i < NV && guard < 2000) begin
            drive(i, rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
            bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) i++;
            next_cycle();
            guard++;
        end
        if (i < NV) begin
            checks++;
            errors++;
            $display("FAIL table_timeout: got %0d accepted expected %0d", i, NV);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) next_cycle();
    endtask

    initial begin
        //            instr         rs1 rs2 rd  imm           il fs af    ab bf    apc az bi rw mr mw ms    j  jr
        vec[0]  = mk(32'hFFF10093, 2, 31, 1,  32'hFFFFFFFF, 0, 0, 3'b000, 0, 3'b000, 0, 0, 1, 1, 0, 0, 3'b000, 0, 0);
        vec[1]  = mk(32'h402081B3, 1, 2,  3,  32'h00000000, 0, 0, 3'b000, 1, 3'b000, 0, 0, 0, 1, 0, 0, 3'b000, 0, 0);
        vec[2]  = mk(32'h4032D293, 5, 3,  5,  32'h00000403, 0, 0, 3'b101, 1, 3'b000, 0, 0, 1, 1, 0, 0, 3'b000, 0, 0);
        vec[3]  = mk(32'hFE208EE3, 1, 2,  29, 32'hFFFFFFFC, 0, 1, 3'b000, 0, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0);
        vec[4]  = mk(32'h12345537, 8, 3,  10, 32'h12345000, 0, 0, 3'b000, 0, 3'b000, 0, 1, 1, 1, 0, 0, 3'b000, 0, 0);
        vec[5]  = mk(32'h00001097, 0, 0,  1,  32'h00001000, 0, 0, 3'b000, 0, 3'b000, 1, 0, 1, 1, 0, 0, 3'b000, 0, 0);
        vec[6]  = mk(32'h008000EF, 0, 8,  1,  32'h00000008, 0, 0, 3'b000, 0, 3'b000, 1, 0, 1, 1, 0, 0, 3'b000, 1, 0);
        vec[7]  = mk(32'h00008067, 1, 0,  0,  32'h00000000, 0, 0, 3'b000, 0, 3'b000, 0, 0, 1, 0, 0, 0, 3'b000, 0, 1);
        vec[8]  = mk(32'h00412283, 2, 4,  5,  32'h00000004, 0, 0, 3'b000, 0, 3'b000, 0, 0, 1, 1, 1, 0, 3'b010, 0, 0);
        vec[9]  = mk(32'hFE512C23, 2, 5,  24, 32'hFFFFFFF8, 0, 0, 3'b000, 0, 3'b000, 0, 0, 1, 0, 0, 1, 3'b010, 0, 0);
        vec[10] = mk(32'h00000000, 0, 0,  0,  32'h00000000, 1, 0, 3'b000, 0, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0);
        vec[11] = mk(32'h40009093, 1, 0,  1,  32'h00000000, 1, 0, 3'b000, 0, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0);
        vec[12] = mk(32'h00002063, 0, 0,  0,  32'h00000000, 1, 0, 3'b000, 0, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0);
        vec[13] = mk(32'h40001033, 0, 0,  0,  32'h00000000, 1, 0, 3'b000, 0, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0);
        vec[14] = mk(32'h0020C463, 1, 2,  8,  32'h00000008, 0, 1, 3'b000, 0, 3'b100, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0);
        vec[15] = mk(32'h0062C233, 5, 6,  4,  32'h00000000, 0, 0, 3'b100, 0, 3'b000, 0, 0, 0, 1, 0, 0, 3'b000, 0, 0);

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.in_pc     = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        cur_exp       = vec[0];

        @(negedge clk);
        chk("reset out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset out_pc", bus.out_pc, RST_PC);
        chk("reset in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset out_imm", bus.out_imm, 32'd0);
        chk("reset out_reg_write", 32'(bus.out_reg_write), 32'd0);
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        run_table(1'b0);
        run_table(1'b1);

        // Backpressure: ADDI held for two cycles while SUB waits
        drive(I_ADDI, 1'b1);
        bus.out_ready = 1'b1;
        next_cycle();
        drive(I_SUB, 1'b1);
        bus.out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("bp in_ready", 32'(bus.in_ready), 32'd0);
            chk("bp out_valid", 32'(bus.out_valid), 32'd1);
            chk("bp held imm", bus.out_imm, 32'hFFFFFFFF);
            chk("bp held rd", 32'(bus.out_rd), 32'd1);
            next_cycle();
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp release in_ready", 32'(bus.in_ready), 32'd1);
        next_cycle();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("bp sub out_valid", 32'(bus.out_valid), 32'd1);
        chk("bp sub rd", 32'(bus.out_rd), 32'd3);
        chk("bp sub alu_bit", 32'(bus.out_alu_bit), 32'd1);
        next_cycle();
        next_cycle();

        // Flush on the acceptance cycle
        drive(I_SUB, 1'b1);
        bus.flush = 1'b1;
        next_cycle();
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        @(negedge clk);
        chk("flush accept out_valid", 32'(bus.out_valid), 32'd0);
        next_cycle();

        // Flush of a held bundle
        drive(I_ADDI, 1'b1);
        next_cycle();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("flush held pre out_valid", 32'(bus.out_valid), 32'd1);
        next_cycle();
        bus.flush = 1'b1;
        next_cycle();
        bus.flush = 1'b0;
        @(negedge clk);
        chk("flush held out_valid", 32'(bus.out_valid), 32'd0);
        next_cycle();

        // Illegal all-zero word, then asynchronous reset mid-cycle
        bus.out_ready = 1'b1;
        drive(I_ILL0, 1'b1);
        next_cycle();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("ill out_valid", 32'(bus.out_valid), 32'd1);
        chk("ill out_illegal", 32'(bus.out_illegal), 32'd1);
        chk("ill reg_write", 32'(bus.out_reg_write), 32'd0);
        chk("ill mem_write", 32'(bus.out_mem_write), 32'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async rst out_valid", 32'(bus.out_valid), 32'd0);
        chk("async rst out_pc", bus.out_pc, RST_PC);
        chk("async rst out_illegal", 32'(bus.out_illegal), 32'd0);
        chk("async rst in_ready", 32'(bus.in_ready), 32'd1);
        sb_q.delete();
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        chk("scoreboard drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv32i_decode_stage.md
Name: rv32i_decode_stage

Overview:
Registered decode stage of the RV32I core. It takes a fetched instruction word and PC and produces the ALU and branch-compare control fields: FuncSel, AluFunc[2:0], Alu_bit and BrFunc[2:0]. It also produces operand-select controls, register indices, the sign-extended immediate and the write/memory controls. It is the driver end of the ALU control interface. A single output register with a valid/ready handshake decouples fetch from execute.

Parameters:
RESET_PC, 32'h0000_0000, value loaded into out_pc on reset.

Ports:
clk  in  1  core clock; all state updates on rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  fetch presents a valid instruction.
in_ready  out  1  stage accepts the instruction this cycle.
in_instr  in  32  instruction word.
in_pc  in  32  PC of in_instr.
flush  in  1  discard the held instruction and any instruction accepted this cycle.
out_valid  out  1  decoded bundle valid.
out_ready  in  1  execute consumes the bundle this cycle.
out_pc  out  32  registered PC.
out_rs1, out_rs2, out_rd  out  5 each  register indices (instr[19:15], [24:20], [11:7]).
out_imm  out  32  sign-extended immediate for the instruction format.
out_func_sel  out  1  0 = ALU operation, 1 = branch compare.
out_alu_func  out  3  AluFunc.
out_alu_bit  out  1  Alu_bit (SUB/SRA select).
out_br_func  out  3  BrFunc.
out_src_a_pc  out  1  ALU A operand = PC (AUIPC, JAL).
out_src_a_zero  out  1  ALU A operand = 0 (LUI).
out_src_b_imm  out  1  ALU B operand = immediate.
out_reg_write  out  1  write rd.
out_mem_read, out_mem_write  out  1 each  load or store.
out_mem_size  out  3  funct3 for loads and stores.
out_jump, out_jalr  out  1 each  JAL or JALR.
out_illegal  out  1  instruction is not legal RV32I.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_pc=RESET_PC, all other outputs 0. in_ready is combinational and is therefore 1 while reset is asserted.
- Handshake: in_ready = !out_valid || out_ready. The stage loads when in_valid && in_ready. Latency is 1 cycle from acceptance to out_valid. The bundle holds stable while out_valid && !out_ready.
- Valid update: out_valid_next = flush ? 0 : (load ? 1 : (out_ready ? 0 : out_valid)).
- Flush priority: flush overrides a simultaneous load. Data registers may update, but out_valid must be 0.
- Illegal when any of the following holds:
  - instr[1:0] != 2'b11, or the opcode is not one of LUI/AUIPC/JAL/JALR/BRANCH/LOAD/STORE/OP-IMM/OP.
  - BRANCH with funct3 = 010 or 011.
  - LOAD with funct3 = 011, 110 or 111.
  - STORE with funct3 > 010.
  - JALR with funct3 != 000.
  - OP with funct7 not in {0000000, 0100000}, or funct7 = 0100000 with funct3 not in {000, 101}.
  - OP-IMM with funct3 = 001 and instr[31:25] != 0.
  - OP-IMM with funct3 = 101 and instr[31:25] not in {0000000, 0100000}.
- Illegal bundle: out_illegal=1, out_valid follows the handshake, and reg_write, mem_read, mem_write, jump and jalr are all 0.
- ALU control:
  - OP: func_sel=0, alu_func=funct3, alu_bit=instr[30].
  - OP-IMM: alu_func=funct3, alu_bit = (funct3==101) & instr[30], src_b_imm=1.
  - LOAD, STORE, JALR: alu_func=000, alu_bit=0, src_b_imm=1.
  - AUIPC: add with src_a_pc=1 and src_b_imm=1. LUI: add with src_a_zero=1 and src_b_imm=1.
  - JAL: src_a_pc=1, jump=1.
  - BRANCH: func_sel=1, br_func=funct3, src_b_imm=0.
- Immediates:
  - I-type: sext(instr[31:20]).
  - S-type: sext({instr[31:25], instr[11:7]}).
  - B-type: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - U-type: {instr[31:12], 12'b0}.
  - J-type: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - OP and illegal: 0.
- reg_write: 1 for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM and OP. It is forced to 0 when rd = x0.

Test Plan:
- ADDI x1,x2,-1 (0xFFF10093), out_ready=1 → next cycle: out_valid=1, rs1=2, rd=1, imm=0xFFFFFFFF, alu_func=000, alu_bit=0, src_b_imm=1, reg_write=1.
- SUB x3,x1,x2 (0x402081B3) → alu_func=000, alu_bit=1, rs1=1, rs2=2, rd=3, imm=0. SRAI x5,x5,3 (0x4032D293) → alu_func=101, alu_bit=1.
- BEQ x1,x2,-4 (0xFE208EE3) → func_sel=1, br_func=000, imm=0xFFFFFFFC, reg_write=0.
- Backpressure: accept ADDI, then hold out_ready=0 for 2 cycles while in_valid=1 with SUB → in_ready=0 and the ADDI bundle stays unchanged; on out_ready=1, SUB is loaded the same cycle and appears on the next cycle.
- flush=1 in the same cycle as acceptance of SUB → out_valid=0 next cycle; a held bundle is also dropped.
- in_instr=0x00000000 → out_illegal=1, reg_write=0, mem_write=0. Then assert rst_n=0 mid-stream → out_valid=0 and out_pc=RESET_PC immediately, without waiting for a clock edge.
